// File: rtl/star_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : star_scan_scheduler
//  Purpose  : Star-finding sequencer. Raster-scans a WIDTH x HEIGHT pixel RAM
//             for bright pixels that lie outside every recorded star box.
//             Each such pixel launches the top/bottom measurement engine, and
//             the extents it returns are recorded. The block owns the single
//             RAM read port and hands it to the engine through mem_sel_o.
//  Ports    : clk_i/reset_i      clock, synchronous active-high reset
//             start_i            begin a scan (ignored while busy)
//             pix_val_i          RAM data, one cycle after the address
//             scan_x_o/scan_y_o  scanner RAM address (mem_sel_o = 0)
//             mem_sel_o          0 = scanner owns RAM, 1 = engine owns RAM
//             eng_*              engine launch / result handshake
//             star_*             star record write port and running count
//             busy_o/done_o      scan status; overflow_o = record table full
//  Option   : STAR_SCHED_TIMEOUT_EN adds a 6-bit engine watchdog with the
//             outputs eng_timeout_o and timeout_seen_o.
//  Revision : 1.0 - initial release
// ============================================================================
module star_scan_scheduler #(
    parameter int X_SZ      = 3,
    parameter int Y_SZ      = 3,
    parameter int WIDTH     = 6,
    parameter int HEIGHT    = 6,
    parameter int COL_SZ    = 3,
    parameter int THRESHOLD = 0,
    parameter int MAX_STARS = 4,
    parameter int IDX_SZ    = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [COL_SZ-1:0] pix_val_i,
    output logic [X_SZ-1:0]   scan_x_o,
    output logic [Y_SZ-1:0]   scan_y_o,
    output logic              mem_sel_o,
    output logic              eng_start_o,
    output logic [X_SZ-1:0]   eng_x_o,
    output logic [Y_SZ-1:0]   eng_y_o,
    input  logic              eng_complete_i,
    input  logic [Y_SZ-1:0]   eng_top_i,
    input  logic [Y_SZ-1:0]   eng_bottom_i,
    input  logic [X_SZ-1:0]   eng_mid_i,
    output logic              star_wr_o,
    output logic [IDX_SZ-1:0] star_idx_o,
    output logic [X_SZ-1:0]   star_x_o,
    output logic [Y_SZ-1:0]   star_top_o,
    output logic [Y_SZ-1:0]   star_bottom_o,
    output logic [X_SZ-1:0]   star_mid_o,
    output logic [IDX_SZ:0]   star_count_o,
    output logic              busy_o,
    output logic              done_o,
`ifdef STAR_SCHED_TIMEOUT_EN
    output logic              eng_timeout_o,
    output logic              timeout_seen_o,
`endif
    output logic              overflow_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SCAN_ADDR = 3'd1,
        S_SCAN_CHK  = 3'd2,
        S_LAUNCH    = 3'd3,
        S_WAIT_ENG  = 3'd4,
        S_RECORD    = 3'd5,
        S_NEXT      = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    localparam logic [X_SZ-1:0]   c_xlast  = X_SZ'(WIDTH - 1);
    localparam logic [Y_SZ-1:0]   c_ylast  = Y_SZ'(HEIGHT - 1);
    localparam logic [X_SZ:0]     c_xmax   = (X_SZ + 1)'(WIDTH - 1);
    localparam logic [X_SZ:0]     c_xone   = (X_SZ + 1)'(1);
    localparam logic [IDX_SZ:0]   c_maxcnt = (IDX_SZ + 1)'(MAX_STARS);
    localparam logic [COL_SZ-1:0] c_thresh = COL_SZ'(THRESHOLD);

    state_t            state_q, state_d;
    logic [X_SZ-1:0]   x_q, x_d;
    logic [Y_SZ-1:0]   y_q, y_d;
    logic [X_SZ-1:0]   ex_q, ex_d;
    logic [Y_SZ-1:0]   ey_q, ey_d;
    logic [IDX_SZ:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              first_q, first_d;

    // Recorded star boxes
    logic [X_SZ-1:0]   box_x_q   [MAX_STARS];
    logic [Y_SZ-1:0]   box_top_q [MAX_STARS];
    logic [Y_SZ-1:0]   box_bot_q [MAX_STARS];
    logic [X_SZ-1:0]   box_mid_q [MAX_STARS];

    logic [MAX_STARS-1:0] w_cover;
    logic                 w_covered;
    logic                 w_bright;
    logic                 w_last;
    logic                 w_step;
    logic                 w_rec;
    logic [IDX_SZ-1:0]    w_slot;

`ifdef STAR_SCHED_TIMEOUT_EN
    logic [5:0]        wdog_q, wdog_d;
    logic              tseen_q, tseen_d;
    logic              w_tmo;
`endif

    // ------------------------------------------------------------------
    // Coverage: a stored star with half-width h = mid - x claims columns
    // [x-h-1, mid+h+1] clamped to the image, over rows [top, bottom].
    // One extra bit keeps mid+h+1 from wrapping; the low bound is clamped
    // by comparison instead of subtraction so it cannot wrap below zero.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < MAX_STARS; gi++) begin : g_cover
        localparam logic [IDX_SZ:0] c_slot = (IDX_SZ + 1)'(gi);
        logic [X_SZ:0] w_bx, w_mid, w_h, w_hp1, w_lo, w_hi_raw, w_hi;

        assign w_bx     = {1'b0, box_x_q[gi]};
        assign w_mid    = {1'b0, box_mid_q[gi]};
        assign w_h      = w_mid - w_bx;
        assign w_hp1    = w_h + c_xone;
        assign w_lo     = (w_bx < w_hp1) ? '0 : (w_bx - w_hp1);
        assign w_hi_raw = w_mid + w_hp1;
        assign w_hi     = (w_hi_raw > c_xmax) ? c_xmax : w_hi_raw;

        assign w_cover[gi] = (c_slot < count_q)
                           && (box_top_q[gi] <= y_q) && (y_q <= box_bot_q[gi])
                           && (w_lo <= {1'b0, x_q}) && ({1'b0, x_q} <= w_hi);
    end

    assign w_covered = |w_cover;
    assign w_bright  = (pix_val_i > c_thresh);
    assign w_last    = (x_q == c_xlast) && (y_q == c_ylast);
    assign w_rec     = (state_q == S_RECORD);
    assign w_slot    = count_q[IDX_SZ-1:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        first_d = first_q;
        w_step  = 1'b0;
`ifdef STAR_SCHED_TIMEOUT_EN
        wdog_d  = wdog_q;
        tseen_d = tseen_q;
        w_tmo   = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_SCAN_ADDR;
                    x_d     = '0;
                    y_d     = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
`ifdef STAR_SCHED_TIMEOUT_EN
                    tseen_d = 1'b0;
`endif
                end
            end
            S_SCAN_ADDR: state_d = S_SCAN_CHK;
            S_SCAN_CHK: begin
                if (!w_bright || w_covered) begin
                    // Skipped pixels step straight to the next address so a
                    // pixel costs two cycles; the final pixel goes through
                    // NEXT, which owns the end-of-frame decision.
                    if (w_last) begin
                        state_d = S_NEXT;
                    end else begin
                        w_step  = 1'b1;
                        state_d = S_SCAN_ADDR;
                    end
                end else if (count_q == c_maxcnt) begin
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    ex_d    = x_q;
                    ey_d    = y_q;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                first_d = 1'b1;
`ifdef STAR_SCHED_TIMEOUT_EN
                wdog_d  = '0;
`endif
                state_d = S_WAIT_ENG;
            end
            S_WAIT_ENG: begin
                // The first wait cycle may still see the previous run's
                // completion level, so it is never trusted.
                first_d = 1'b0;
                if (!first_q && eng_complete_i) begin
                    state_d = S_RECORD;
                end
`ifdef STAR_SCHED_TIMEOUT_EN
                else if (wdog_q == 6'd63) begin
                    w_tmo   = 1'b1;
                    tseen_d = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    wdog_d = wdog_q + 6'd1;
                end
`endif
            end
            S_RECORD: begin
                count_d = count_q + 1'b1;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (w_last) begin
                    state_d = S_DONE;
                end else begin
                    w_step  = 1'b1;
                    state_d = S_SCAN_ADDR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_step) begin
            if (x_q == c_xlast) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ex_q    <= '0;
            ey_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ex_q    <= ex_d;
            ey_q    <= ey_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            first_q <= first_d;
        end
    end

`ifdef STAR_SCHED_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wdog_q  <= '0;
            tseen_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            tseen_q <= tseen_d;
        end
    end

    assign eng_timeout_o  = w_tmo;
    assign timeout_seen_o = tseen_q;
`endif

    // Box table: written once per recorded star into the next free slot
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < MAX_STARS; i++) begin
                box_x_q[i]   <= '0;
                box_top_q[i] <= '0;
                box_bot_q[i] <= '0;
                box_mid_q[i] <= '0;
            end
        end else if (w_rec) begin
            box_x_q[w_slot]   <= ex_q;
            box_top_q[w_slot] <= eng_top_i;
            box_bot_q[w_slot] <= eng_bottom_i;
            box_mid_q[w_slot] <= eng_mid_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs; record fields are gated so they read zero outside RECORD
    // ------------------------------------------------------------------
    assign scan_x_o      = x_q;
    assign scan_y_o      = y_q;
    assign mem_sel_o     = (state_q == S_LAUNCH) || (state_q == S_WAIT_ENG);
    assign eng_start_o   = (state_q == S_LAUNCH);
    assign eng_x_o       = ex_q;
    assign eng_y_o       = ey_q;
    assign star_wr_o     = w_rec;
    assign star_idx_o    = w_rec ? w_slot       : '0;
    assign star_x_o      = w_rec ? ex_q         : '0;
    assign star_top_o    = w_rec ? eng_top_i    : '0;
    assign star_bottom_o = w_rec ? eng_bottom_i : '0;
    assign star_mid_o    = w_rec ? eng_mid_i    : '0;
    assign star_count_o  = count_q;
    assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o        = (state_q == S_DONE);
    assign overflow_o    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_star_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_star_scan_scheduler
//  Purpose  : Self-checking bench for star_scan_scheduler. A pixel RAM model,
//             an engine model and a raster-order reference scheduler build
//             queues of expected launches and records; a per-cycle compare
//             process checks the DUT against them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_star_scan_scheduler;

    localparam int W = 6;
    localparam int H = 6;
    localparam int MAXS = 4;

    typedef struct { int x; int y; } launch_t;
    typedef struct { int idx; int x; int top; int bot; int mid; } rec_t;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [2:0] pix_val;
    logic [2:0] scan_x, scan_y, eng_x, eng_y, eng_top, eng_bottom, eng_mid;
    logic       mem_sel, eng_start, eng_complete, star_wr, busy, done, overflow;
    logic [1:0] star_idx;
    logic [2:0] star_x, star_top, star_bottom, star_mid;
    logic [2:0] star_count;
`ifdef STAR_SCHED_TIMEOUT_EN
    logic       eng_timeout, timeout_seen;
`endif

    logic [2:0] img [0:H-1][0:W-1];
    launch_t    lq[$];
    rec_t       rq[$];
    launch_t    cl;
    rec_t       cr;
    int         tests = 0, fails = 0;
    int         exp_count, exp_ovf;
    int         nls = 0, nwr = 0, ntmo = 0, cyc = 0, t_launch = 0;
    bit         owned = 0, eng_hang = 0;

    always #5 clk = ~clk;

    star_scan_scheduler dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .pix_val_i(pix_val),
        .scan_x_o(scan_x), .scan_y_o(scan_y), .mem_sel_o(mem_sel),
        .eng_start_o(eng_start), .eng_x_o(eng_x), .eng_y_o(eng_y),
        .eng_complete_i(eng_complete), .eng_top_i(eng_top),
        .eng_bottom_i(eng_bottom), .eng_mid_i(eng_mid),
        .star_wr_o(star_wr), .star_idx_o(star_idx), .star_x_o(star_x),
        .star_top_o(star_top), .star_bottom_o(star_bottom),
        .star_mid_o(star_mid), .star_count_o(star_count),
        .busy_o(busy), .done_o(done),
`ifdef STAR_SCHED_TIMEOUT_EN
        .eng_timeout_o(eng_timeout), .timeout_seen_o(timeout_seen),
`endif
        .overflow_o(overflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_bright(input int x, input int y);
        return (x >= 0 && x < W && y >= 0 && y < H) && (img[y][x] > 3'd0);
    endfunction

    // Engine: top is the launch row, bottom extends down the launch column,
    // mid is the centre of the bright run to the right on the launch row.
    function automatic void eng_model(input int x, input int y,
                                      output int t, output int b, output int m);
        int r;
        t = y;
        b = y;
        while (is_bright(x, b + 1)) b++;
        r = x;
        while (is_bright(r + 1, y)) r++;
        m = x + (r - x) / 2;
    endfunction

    // Reference scheduler: walks the frame in raster order and lists what
    // must be launched and recorded.
    task automatic build_expect();
        int bx[MAXS], bt[MAXS], bb[MAXS], bm[MAXS];
        int n, t, b, m, h, lo, hi;
        bit stop, cov;
        lq.delete();
        rq.delete();
        n = 0; exp_ovf = 0; stop = 0;
        for (int y = 0; y < H && !stop; y++) begin
            for (int x = 0; x < W && !stop; x++) begin
                cov = 0;
                for (int i = 0; i < n; i++) begin
                    h  = bm[i] - bx[i];
                    lo = bx[i] - h - 1; if (lo < 0) lo = 0;
                    hi = bm[i] + h + 1; if (hi > W - 1) hi = W - 1;
                    if (y >= bt[i] && y <= bb[i] && x >= lo && x <= hi) cov = 1;
                end
                if (is_bright(x, y) && !cov) begin
                    if (n == MAXS) begin
                        exp_ovf = 1;
                        stop = 1;
                    end else begin
                        eng_model(x, y, t, b, m);
                        lq.push_back('{x: x, y: y});
                        rq.push_back('{idx: n, x: x, top: t, bot: b, mid: m});
                        bx[n] = x; bt[n] = t; bb[n] = b; bm[n] = m;
                        n++;
                    end
                end
            end
        end
        exp_count = n;
    endtask

    task automatic clear_img();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = 3'd0;
    endtask

    // Synchronous-read RAM
    always @(posedge clk)
        pix_val <= img[int'(scan_y) % H][int'(scan_x) % W];

    // Engine: leaves the old completion level up through the first wait
    // cycle, then drops it and answers a couple of cycles later.
    initial begin : engine
        int lx, ly, t, b, m;
        eng_complete = 1'b0; eng_top = '0; eng_bottom = '0; eng_mid = '0;
        forever begin
            @(posedge clk); #1;
            if (eng_start === 1'b1 && !reset) begin
                lx = int'(eng_x); ly = int'(eng_y);
                @(posedge clk); #1;
                @(posedge clk); #1;
                eng_complete = 1'b0;
                if (!eng_hang) begin
                    repeat (2) begin @(posedge clk); #1; end
                    eng_model(lx, ly, t, b, m);
                    eng_top = 3'(t); eng_bottom = 3'(b); eng_mid = 3'(m);
                    eng_complete = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the expected launch/record queues
    initial begin : compare
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                owned = 0;
            end else begin
                if (eng_start) begin
                    nls++;
                    t_launch = cyc;
                    if (lq.size() == 0) chk("launch_unexpected", 1, 0);
                    else begin
                        cl = lq.pop_front();
                        chk("launch_x", int'(eng_x), cl.x);
                        chk("launch_y", int'(eng_y), cl.y);
                    end
                    owned = 1;
                end
                if (star_wr) begin
                    nwr++;
                    if (rq.size() == 0) chk("record_unexpected", 1, 0);
                    else begin
                        cr = rq.pop_front();
                        chk("rec_idx", int'(star_idx), cr.idx);
                        chk("rec_x", int'(star_x), cr.x);
                        chk("rec_top", int'(star_top), cr.top);
                        chk("rec_bottom", int'(star_bottom), cr.bot);
                        chk("rec_mid", int'(star_mid), cr.mid);
                    end
                    owned = 0;
                end
                chk("mem_sel", int'(mem_sel), int'(owned));
                chk("busy_and_done", int'(busy && done), 0);
`ifdef STAR_SCHED_TIMEOUT_EN
                if (eng_timeout) begin
                    ntmo++;
                    chk("timeout_latency", cyc - t_launch, 64);
                    owned = 0;
                end
`endif
            end
        end
    end

    task automatic run_scan(input int mid_start, output int ncyc);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("first_scan_x", int'(scan_x), 0);
        chk("first_scan_y", int'(scan_y), 0);
        chk("busy_after_start", int'(busy), 1);
        chk("count_cleared", int'(star_count), 0);
        chk("ovf_cleared", int'(overflow), 0);
        chk("done_cleared", int'(done), 0);
        ncyc = 0;
        while (!done && ncyc < 2000) begin
            start = (ncyc == mid_start);
            @(posedge clk); #1;
            ncyc++;
        end
        start = 1'b0;
        chk("done_reached", int'(done), 1);
    endtask

    task automatic end_checks();
        chk("star_count", int'(star_count), exp_count);
        chk("overflow", int'(overflow), exp_ovf);
        chk("busy_at_end", int'(busy), 0);
        chk("launches_left", lq.size(), 0);
        chk("records_left", rq.size(), 0);
    endtask

    initial begin : main
        int n, nls0, nwr0;
        reset = 1'b1; start = 1'b0;
        clear_img();
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mem_sel", int'(mem_sel), 0);
        chk("rst_eng_start", int'(eng_start), 0);
        chk("rst_star_wr", int'(star_wr), 0);
        chk("rst_count", int'(star_count), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_scan_xy", int'({scan_x, scan_y}), 0);
        chk("rst_eng_xy", int'({eng_x, eng_y}), 0);
        reset = 1'b0;

        // Blank frame: 2*W*H+1 cycles, nothing launched
        build_expect();
        nls0 = nls;
        run_scan(-1, n);
        chk("blank_cycles", n, 73);
        chk("blank_launches", nls - nls0, 0);
        end_checks();

        // Single 2x2 star
        clear_img();
        img[1][2] = 3'd5; img[1][3] = 3'd7; img[2][2] = 3'd1; img[2][3] = 3'd4;
        build_expect();
        chk("model_quad_count", exp_count, 1);
        chk("model_quad_rec", rq[0].x * 1000 + rq[0].top * 100 + rq[0].bot * 10 + rq[0].mid, 2122);
        nls0 = nls; nwr0 = nwr;
        run_scan(-1, n);
        end_checks();
        chk("quad_launches", nls - nls0, 1);
        chk("quad_records", nwr - nwr0, 1);

        // Start mid-scan is ignored; restart after done repeats the records
        build_expect();
        run_scan(30, n);
        end_checks();
        build_expect();
        run_scan(-1, n);
        end_checks();

        // Wide star: left bound saturates at column 0
        clear_img();
        img[2][1] = 3'd2; img[2][2] = 3'd2; img[2][3] = 3'd2; img[2][4] = 3'd2;
        img[3][0] = 3'd3; img[3][1] = 3'd3;
        build_expect();
        chk("model_wide_count", exp_count, 1);
        run_scan(-1, n);
        end_checks();

        // Five isolated pixels: table fills and the fifth overflows
        clear_img();
        img[0][0] = 3'd1; img[0][5] = 3'd1; img[3][0] = 3'd1; img[3][5] = 3'd1;
        img[5][2] = 3'd1;
        build_expect();
        chk("model_five_count", exp_count, 4);
        chk("model_five_ovf", exp_ovf, 1);
        nls0 = nls;
        run_scan(-1, n);
        end_checks();
        chk("five_launches", nls - nls0, 4);
        chk("five_done", int'(done), 1);

        // Reset while waiting on the engine, then a clean rescan
        clear_img();
        img[1][2] = 3'd5; img[1][3] = 3'd7; img[2][2] = 3'd1; img[2][3] = 3'd4;
        build_expect();
        eng_hang = 1;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (!eng_start && n < 500) begin @(posedge clk); #1; n++; end
        chk("launch_before_reset", int'(eng_start), 1);
        repeat (4) begin @(posedge clk); #1; end
        chk("in_wait_mem_sel", int'(mem_sel), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_mem_sel", int'(mem_sel), 0);
        chk("mid_rst_count", int'(star_count), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_eng_start", int'(eng_start), 0);
        eng_hang = 0;
        build_expect();
        run_scan(-1, n);
        end_checks();

        // Engine that never answers
        clear_img();
        img[1][1] = 3'd6;
        lq.delete(); rq.delete();
        lq.push_back('{x: 1, y: 1});
        eng_hang = 1;
        nwr0 = nwr;
`ifdef STAR_SCHED_TIMEOUT_EN
        exp_count = 0; exp_ovf = 0;
        run_scan(-1, n);
        end_checks();
        chk("timeout_pulses", ntmo, 1);
        chk("timeout_seen", int'(timeout_seen), 1);
        chk("timeout_no_record", nwr - nwr0, 0);
`else
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (200) begin @(posedge clk); #1; end
        chk("hang_busy", int'(busy), 1);
        chk("hang_mem_sel", int'(mem_sel), 1);
        chk("hang_done", int'(done), 0);
        chk("hang_no_record", nwr - nwr0, 0);
        chk("hang_launch_consumed", lq.size(), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
`endif
        eng_hang = 0;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
